// File: rtl/memory_pkg.sv
// ---------------------------------------------------------------------------
// memory_pkg
// Shared types and helpers for the memory-side bus responder.
//   mem_state_e : responder FSM states
//   MEM_DATA_W  : default data bus width
//   MEM_ADDR_W  : default address bus width
//   in_range()  : full-width address range check against the implemented depth
// ---------------------------------------------------------------------------
package memory_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRIVE
   } mem_state_e;

   localparam int unsigned MEM_DATA_W = 16;
   localparam int unsigned MEM_ADDR_W = 16;

   // Addresses are zero-extended to 32 bits by the caller.
   function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/memory_array.sv
// ---------------------------------------------------------------------------
// memory_array
// Single-port word array: synchronous write, combinational read. No reset.
//   i_clk     : write clock
//   i_we      : write enable, one word per posedge
//   i_wr_addr : write index
//   i_wr_data : write data
//   i_rd_addr : combinational read index
//   o_rd_data : word at i_rd_addr
// ---------------------------------------------------------------------------
module memory_array #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]  i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
// Memory-side target on the shared rd/wr/addr/data bus. Accepts writes into
// an internal array, returns read data on the bidirectional bus after
// RD_LATENCY posedges, and flags collisions and out-of-range accesses.
//   clk      : bus clock
//   rst_n    : asynchronous active-low reset
//   addr     : word address
//   rd       : read request (level)
//   wr       : write strobe
//   data     : shared bus; driven here only while rd_valid is high
//   rd_valid : high exactly while this block drives data
//   err      : one-cycle protocol-error pulse
//   wr_count : accepted writes, saturating
// ---------------------------------------------------------------------------
module memory_responder
   import memory_pkg::*;
#(
   parameter int unsigned DATA_W     = MEM_DATA_W,
   parameter int unsigned ADDR_W     = MEM_ADDR_W,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   inout  wire  [DATA_W-1:0] data,
   output logic              rd_valid,
   output logic              err,
   output logic [15:0]       wr_count
);

   localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  LAT_LOAD = 4'(RD_LATENCY - 1);

   mem_state_e        r_state;
   logic [3:0]        r_lat_cnt;
   logic [IDX_W-1:0]  r_rd_idx;
   logic              r_rd_oor;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_err;
   logic [15:0]       r_wr_count;

   logic              w_addr_ok;
   logic              w_wr_ok;
   logic              w_capture;
   logic [IDX_W-1:0]  w_addr_idx;
   logic [IDX_W-1:0]  w_rd_idx;
   logic [DATA_W-1:0] w_mem_rdata;

   assign w_addr_ok  = in_range(32'(addr), DEPTH);
   assign w_wr_ok    = wr & w_addr_ok;
   assign w_capture  = (r_state == IDLE) & rd & ~wr;
   assign w_addr_idx = addr[IDX_W-1:0];
   // With RD_LATENCY=1 the word is fetched on the capture edge, before r_rd_idx is loaded.
   assign w_rd_idx   = (r_state == IDLE) ? w_addr_idx : r_rd_idx;

   memory_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .i_clk     (clk),
      .i_we      (w_wr_ok),
      .i_wr_addr (w_addr_idx),
      .i_wr_data (data),
      .i_rd_addr (w_rd_idx),
      .o_rd_data (w_mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_lat_cnt  <= '0;
         r_rd_idx   <= '0;
         r_rd_oor   <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= (wr & ~w_addr_ok) | (rd & wr) | (w_capture & ~w_addr_ok);
         if (wr || !rd) begin
            // Dropped rd, or any write (collision when rd is also high), ends the read.
            r_state    <= IDLE;
            r_rd_valid <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  r_rd_idx <= w_addr_idx;
                  r_rd_oor <= ~w_addr_ok;
                  if (RD_LATENCY <= 1) begin
                     r_state    <= DRIVE;
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= w_addr_ok ? w_mem_rdata : '0;
                  end else begin
                     r_state   <= WAIT;
                     r_lat_cnt <= LAT_LOAD;
                  end
               end
               WAIT: begin
                  if (r_lat_cnt == 4'd0) begin
                     r_state    <= DRIVE;
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= r_rd_oor ? '0 : w_mem_rdata;
                  end else begin
                     r_lat_cnt <= r_lat_cnt - 4'd1;
                  end
               end
               DRIVE: begin
                  // Held while rd stays high; addr changes are ignored.
               end
               default: begin
                  r_state    <= IDLE;
                  r_rd_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_count <= '0;
      end else if (w_wr_ok && (r_wr_count != 16'hFFFF)) begin
         r_wr_count <= r_wr_count + 16'd1;
      end
   end

   assign data     = r_rd_valid ? r_rd_data : {DATA_W{1'bz}};
   assign rd_valid = r_rd_valid;
   assign err      = r_err;
   assign wr_count = r_wr_count;

endmodule

// File: tb/tb_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_responder
// Directed stimulus with a read scoreboard: each issued read pushes its
// expected data and first-valid cycle; a negedge monitor pops on every
// rd_valid rise and checks held data and bus release. A second instance
// with RD_LATENCY=4 covers aborted-wait and longer latency.
// ---------------------------------------------------------------------------
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        tb_en = 1'b0;
   logic [15:0] tb_drv = '0;
   wire  [15:0] data;
   logic        rd_valid;
   logic        err;
   logic [15:0] wr_count;

   logic [15:0] addr4 = '0;
   logic        rd4 = 1'b0;
   logic        wr4 = 1'b0;
   logic        tb_en4 = 1'b0;
   logic [15:0] tb_drv4 = '0;
   wire  [15:0] data4;
   logic        rd_valid4;
   logic        err4;
   logic [15:0] wr_count4;

   // Undriven bus reads back as all ones.
   pullup u_pull (data);
   pullup u_pull4 (data4);

   assign data  = tb_en  ? tb_drv  : 16'hzzzz;
   assign data4 = tb_en4 ? tb_drv4 : 16'hzzzz;

   memory_responder u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr),
      .rd       (rd),
      .wr       (wr),
      .data     (data),
      .rd_valid (rd_valid),
      .err      (err),
      .wr_count (wr_count)
   );

   memory_responder #(
      .RD_LATENCY (4)
   ) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr     (addr4),
      .rd       (rd4),
      .wr       (wr4),
      .data     (data4),
      .rd_valid (rd_valid4),
      .err      (err4),
      .wr_count (wr_count4)
   );

   typedef struct {
      logic [15:0] d;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   err_seen = 0;
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Inputs change 1 time unit after the negedge; the monitor samples on the negedge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
      addr   = a;
      tb_drv = d;
      tb_en  = 1'b1;
      wr     = 1'b1;
      step();
      wr     = 1'b0;
      tb_en  = 1'b0;
   endtask

   // Capture happens on the next posedge; first valid negedge is RD_LATENCY later.
   task automatic rd_word(input logic [15:0] a, input logic [15:0] d, input int hold);
      addr = a;
      rd   = 1'b1;
      exp_q.push_back('{d, cyc + 3});
      repeat (hold) step();
      rd = 1'b0;
      step();
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (err) err_seen++;
      if (rd_valid) begin
         if (!prev_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rd_valid", 16'(rd_valid), 16'h0);
            end else begin
               cur = exp_q.pop_front();
               check("read_data", data, cur.d);
               check("read_latency_cycle", 16'(cyc), 16'(cur.cyc));
            end
         end else begin
            check("read_data_held", data, cur.d);
         end
      end else if (!tb_en) begin
         check("bus_released", data, 16'hFFFF);
      end
      prev_valid = rd_valid;
   end

   initial begin
      int   e0;
      logic seen_v;
      logic seen_e;

      // Reset state
      step();
      step();
      check("reset_rd_valid", 16'(rd_valid), 16'h0);
      check("reset_err", 16'(err), 16'h0);
      check("reset_wr_count", wr_count, 16'h0);
      check("reset_bus", data, 16'hFFFF);
      rst_n = 1'b1;
      step();

      // Write then read back with latency 2
      wr_word(16'd3, 16'hA5A5);
      check("wr_count_first", wr_count, 16'd1);
      rd_word(16'd3, 16'hA5A5, 3);
      check("wr_count_after_read", wr_count, 16'd1);

      // Held read across several cycles
      wr_word(16'd7, 16'h1234);
      rd_word(16'd7, 16'h1234, 5);
      check("wr_count_second", wr_count, 16'd2);

      // Collision during WAIT
      e0   = err_seen;
      addr = 16'd5;
      rd   = 1'b1;
      step();
      tb_drv = 16'h00FF;
      tb_en  = 1'b1;
      wr     = 1'b1;
      step();
      wr    = 1'b0;
      tb_en = 1'b0;
      rd    = 1'b0;
      step();
      step();
      check("collision_err_pulses", 16'(err_seen - e0), 16'd1);
      check("collision_wr_count", wr_count, 16'd3);
      rd_word(16'd5, 16'h00FF, 3);

      // Out-of-range write and read; 300 aliases index 44 in the low bits
      wr_word(16'd44, 16'h4444);
      e0 = err_seen;
      wr_word(16'd300, 16'hBEEF);
      step();
      check("oor_write_dropped", wr_count, 16'd4);
      rd_word(16'd300, 16'h0000, 3);
      check("oor_err_pulses", 16'(err_seen - e0), 16'd2);
      rd_word(16'd44, 16'h4444, 3);

      // Reset mid-DRIVE
      addr = 16'd7;
      rd   = 1'b1;
      exp_q.push_back('{16'h1234, cyc + 3});
      step();
      step();
      step();
      check("pre_reset_valid", 16'(rd_valid), 16'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_bus", data, 16'hFFFF);
      check("async_reset_rd_valid", 16'(rd_valid), 16'h0);
      check("async_reset_wr_count", wr_count, 16'h0);
      step();
      rd = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      rd_word(16'd7, 16'h1234, 3);

      // RD_LATENCY=4: drop rd during WAIT
      addr4 = 16'd0;
      rd4   = 1'b1;
      step();
      step();
      rd4    = 1'b0;
      seen_v = 1'b0;
      seen_e = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         seen_v = seen_v | rd_valid4;
         seen_e = seen_e | err4;
      end
      check("lat4_abort_no_valid", 16'(seen_v), 16'h0);
      check("lat4_abort_no_err", 16'(seen_e), 16'h0);

      // RD_LATENCY=4: full read
      addr4   = 16'd9;
      tb_drv4 = 16'h0C0C;
      tb_en4  = 1'b1;
      wr4     = 1'b1;
      step();
      wr4    = 1'b0;
      tb_en4 = 1'b0;
      rd4    = 1'b1;
      step();
      step();
      step();
      step();
      check("lat4_not_early", 16'(rd_valid4), 16'h0);
      step();
      check("lat4_valid", 16'(rd_valid4), 16'h1);
      check("lat4_data", data4, 16'h0C0C);
      rd4 = 1'b0;
      step();
      check("lat4_release", 16'(rd_valid4), 16'h0);
      check("lat4_bus_released", data4, 16'hFFFF);

      step();
      check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
